global_buffer_arbiter: RTL and testbench
========================================

Name: global_buffer_arbiter

Overview:
Shares the single-port global buffer between NUM_REQ requesters, such as DMA-in, PE-array operand fetch and writeback. Each requester has a valid/ready request channel and a read-response strobe. Arbitration is round-robin, and a requester can lock the port for a burst, capped at MAX_BURST beats. The block sits directly in front of the global buffer and drives its ce/we/addr/wdata. It tags the buffer's registered read data back to the issuing requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, buffer word width
- ADDR_WIDTH, 16, buffer address width
- MAX_BURST, 16, maximum consecutive beats granted to one locked owner

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_we  in  NUM_REQ  1=write, 0=read
- req_last  in  NUM_REQ  1=final beat of the burst (single beats set 1)
- req_addr  in  NUM_REQ*ADDR_WIDTH  flat; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flat, same packing
- req_ready  out  NUM_REQ  one-hot or zero; beat accepted when valid&ready
- rsp_valid  out  NUM_REQ  one-hot; read data for requester i is valid this cycle
- rsp_rdata  out  DATA_WIDTH  broadcast read data (= mem_rdata)
- mem_ce  out  1  to buffer ce
- mem_we  out  1  to buffer we
- mem_addr  out  ADDR_WIDTH  to buffer addr
- mem_wdata  out  DATA_WIDTH  to buffer wdata
- mem_rdata  in  DATA_WIDTH  from buffer (registered, 1-cycle read latency)
- busy  out  1  high while in LOCK state
- grant_id  out  $clog2(NUM_REQ)  current/last granted requester

Behaviour:
- Reset: state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, rsp_valid=0, busy=0.
  - While rst_n is low, req_ready=0 and mem_ce=0; these are combinational outputs gated by state.
- Clock and reset: one clock, clk. rst_n is asynchronous assert; deassertion is synchronised upstream.
- IDLE: the winner is the first i with req_valid[i], searching from rr_ptr upward with wrap.
  - Winner gets req_ready in the same cycle, so acceptance is combinational.
  - No valid requests → mem_ce=0, all ready=0.
- On an accepted beat: mem_ce=1, mem_we=req_we[w], mem_addr/mem_wdata = requester w's fields.
- IDLE, accepted beat with req_last=1 → stay in IDLE, rr_ptr=(w+1) mod NUM_REQ.
- IDLE, accepted beat with req_last=0 → go to LOCK, owner=w, beat_cnt=1.
- LOCK: only the owner can receive ready; all other requesters see ready=0.
  - Owner valid=0 → idle cycle, lock is held, beat_cnt unchanged.
- LOCK, accepted beat:
  - beat_cnt increments.
  - If req_last=1, or beat_cnt+1==MAX_BURST, go to IDLE with rr_ptr=owner+1.
  - Forced release at MAX_BURST does not abort the owner's burst. The next beat re-arbitrates and the owner's remaining beats are treated as a new burst.
- Read response: rsp_valid[w] is registered and asserts exactly 1 cycle after an accepted read beat (we=0).
  - It coincides with the buffer's rdata update. rsp_rdata=mem_rdata unregistered.
  - Back-to-back reads give back-to-back rsp_valid with no bubble.
  - Writes produce no rsp_valid.
- Write/read ordering: a write followed by a read to the same address in the next cycle returns the new data. The buffer writes at the edge, so no hazard logic is needed.
- grant_id updates on each accepted beat; it is held otherwise.
- A requester must hold valid, we, addr and wdata stable until ready. Dropping valid without acceptance is legal and has no effect.
- Reset mid-burst: lock is released immediately. A pending rsp_valid is dropped and requesters must reissue.
- There are no responses for unaccepted beats. Address range checking is the requester's responsibility.

Decomposition:
- npu_definitions.vh holds DATA_WIDTH, ADDR_WIDTH, NUM_GB_REQ and GB_MAX_BURST defaults, plus the state encodings ARB_IDLE=1'b0 and ARB_LOCK=1'b1.
- One sub-module, rr_priority_pick: combinational round-robin find-first from rr_ptr. Outputs a one-hot grant and an encoded index; reusable by other arbiters.

Test Plan:
- Single read: req0 read addr 0x0010 (mem=0xDEADBEEF) → ready0 same cycle, mem_ce=1 we=0, next cycle rsp_valid=4'b0001 and rsp_rdata=0xDEADBEEF.
- Round-robin fairness: all 4 valid, single-beat reads, held 8 cycles → grant order 0,1,2,3,0,1,2,3, rsp_valid one-hot following a cycle later.
- Burst lock: req1 writes 4 beats (last on beat 4) while req2 requests → req2 ready=0 for 4 cycles, granted cycle 5, busy high during beats 2-4.
- MAX_BURST=4 cap: req0 issues 10 beats with no last, req3 valid → after beat 4 lock releases, req3 gets the next beat, then req0 resumes.
- Write-then-read: req2 writes 0x1234 to 0x0100, next cycle req2 reads 0x0100 → rsp returns 0x1234.
- Reset mid-burst: assert rst_n low during LOCK beat 2 → ready=0, mem_ce=0, rsp_valid=0 immediately. After release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/global_buffer_arbiter_pkg.sv
// Shared types and default sizing for the global buffer arbiter and its requesters.
package global_buffer_arbiter_pkg;

  localparam int GB_DATA_WIDTH = 32;
  localparam int GB_ADDR_WIDTH = 16;
  localparam int NUM_GB_REQ    = 4;
  localparam int GB_MAX_BURST  = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Round-robin pointer advance with wrap at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/global_buffer_arbiter_if.sv
// Requester-side bundle: per-requester valid/ready request channel plus tagged read response.
interface global_buffer_arbiter_if
  import global_buffer_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_GB_REQ,
  parameter int DATA_WIDTH = GB_DATA_WIDTH,
  parameter int ADDR_WIDTH = GB_ADDR_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_we, req_last, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_last, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin find-first: first set bit of req at or above ptr, with wrap.
module rr_priority_pick #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/global_buffer_arbiter.sv
// Round-robin arbiter with burst locking in front of the single-port global buffer;
// tags the buffer's registered read data back to the issuing requester.
module global_buffer_arbiter
  import global_buffer_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_GB_REQ,
  parameter int DATA_WIDTH = GB_DATA_WIDTH,
  parameter int ADDR_WIDTH = GB_ADDR_WIDTH,
  parameter int MAX_BURST  = GB_MAX_BURST,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  global_buffer_arbiter_if.slave bus,
  output logic                   mem_ce,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0] rsp_vld_p1, rsp_vld_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   win_idx;
  logic               pick_any;

  logic [IDX_W-1:0]   sel;
  logic [NUM_REQ-1:0] ready;
  logic               accept;
  logic               sel_we;
  logic               sel_last;

  rr_priority_pick #(.N(NUM_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (win_idx),
    .any (pick_any)
  );

  // Acceptance is combinational; reset gates it so nothing reaches the buffer while rst_n is low.
  always_comb begin
    sel    = (state_q == ARB_LOCK) ? owner_q : win_idx;
    accept = 1'b0;
    ready  = '0;
    if (rst_n) begin
      if (state_q == ARB_LOCK) begin
        accept = bus.req_valid[owner_q];
        ready  = accept ? (NUM_REQ'(1) << owner_q) : '0;
      end else begin
        accept = pick_any;
        ready  = pick_gnt;
      end
    end
    sel_we   = bus.req_we[sel];
    sel_last = bus.req_last[sel];
  end

  assign bus.req_ready = ready;
  assign mem_ce        = accept;
  assign mem_we        = sel_we;
  assign mem_addr      = bus.req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_wdata     = bus.req_wdata[sel*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    rsp_vld_d  = (accept && !sel_we) ? (NUM_REQ'(1) << sel) : '0;
    case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          grant_d = sel;
          if (sel_last || MAX_BURST <= 1) begin
            rr_ptr_d = IDX_W'(wrap_inc(int'(sel), NUM_REQ));
          end else begin
            state_d    = ARB_LOCK;
            owner_d    = sel;
            beat_cnt_d = CNT_W'(1);
          end
        end
      end
      ARB_LOCK: begin
        if (accept) begin
          grant_d    = sel;
          beat_cnt_d = beat_cnt_q + 1'b1;
          // Cap release only ends the lock; the owner's remaining beats re-arbitrate as a new burst.
          if (sel_last || (int'(beat_cnt_q) + 1 >= MAX_BURST)) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = IDX_W'(wrap_inc(int'(owner_q), NUM_REQ));
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      rsp_vld_p1 <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      rsp_vld_p1 <= rsp_vld_d;
    end
  end

  // Response stage: strobe lines up with the buffer's registered read data.
  assign bus.rsp_valid = rsp_vld_p1;
  assign bus.rsp_rdata = mem_rdata;
  assign busy          = (state_q == ARB_LOCK);
  assign grant_id      = grant_q;

endmodule

// File: tb/tb_global_buffer_arbiter.sv
// Directed bench for global_buffer_arbiter with a behavioural 1-cycle-latency buffer model.
module tb_global_buffer_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int MB = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          mem_ce, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    grant_id;
  logic [DW-1:0] mem [0:65535];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  global_buffer_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  global_buffer_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_all();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_last  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic last,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]          = v;
    bus.req_we[i]             = we;
    bus.req_last[i]           = last;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clr_all();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (mem_ce !== 1'b0) begin failures++; $display("FAIL rst_mem_ce got=%b exp=0", mem_ce); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id); end
    checks++; if (bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0000", bus.rsp_valid); end
    @(negedge clk); #1;
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready_clk got=%b exp=0000", bus.req_ready); end
    @(negedge clk);
    clr_all();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    set_req(0, 1'b1, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL sr_wr_ready got=%b exp=0001", bus.req_ready); end
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sr_wr_bus got we=%b wdata=%h exp we=1 wdata=deadbeef", mem_we, mem_wdata); end
    step();
    bus.req_we[0] = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL sr_rd_ready got=%b exp=0001", bus.req_ready); end
    checks++; if (mem_ce !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin failures++; $display("FAIL sr_rd_bus got ce=%b we=%b addr=%h exp ce=1 we=0 addr=0010", mem_ce, mem_we, mem_addr); end
    checks++; if (bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL sr_wr_no_rsp got=%b exp=0000", bus.rsp_valid); end
    step();
    clr_all();
    #1;
    checks++; if (bus.rsp_valid !== 4'b0001) begin failures++; $display("FAIL sr_rsp_valid got=%b exp=0001", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sr_rsp_rdata got=%h exp=deadbeef", bus.rsp_rdata); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL sr_grant_id got=%0d exp=0", grant_id); end
    step();
    #1;
    checks++; if (bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL sr_rsp_clear got=%b exp=0000", bus.rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy, exp_rsp;
    logic [1:0] exp_gid;
    apply_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 1'b1, AW'(16'h0040 + i), '0);
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      exp_rsp = (k == 0) ? 4'b0000 : (4'b0001 << ((k - 1) % 4));
      exp_gid = (k == 0) ? 2'd0 : 2'((k - 1) % 4);
      checks++; if (bus.req_ready !== exp_rdy) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, bus.req_ready, exp_rdy); end
      checks++; if (bus.rsp_valid !== exp_rsp) begin failures++; $display("FAIL rr_rsp[%0d] got=%b exp=%b", k, bus.rsp_valid, exp_rsp); end
      checks++; if (grant_id !== exp_gid) begin failures++; $display("FAIL rr_gid[%0d] got=%0d exp=%0d", k, grant_id, exp_gid); end
      step();
    end
    clr_all();
    #1;
    checks++; if (bus.rsp_valid !== 4'b1000) begin failures++; $display("FAIL rr_rsp_last got=%b exp=1000", bus.rsp_valid); end
    checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL rr_gid_last got=%0d exp=3", grant_id); end
  endtask

  task automatic test_burst_lock();
    logic [DW-1:0] exp_d;
    apply_reset();
    set_req(2, 1'b1, 1'b0, 1'b1, 16'h0002, '0);
    for (int b = 0; b < 4; b++) begin
      exp_d = DW'(32'hA0 + b);
      set_req(1, 1'b1, 1'b1, (b == 3), AW'(16'h0020 + b), exp_d);
      #1;
      checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL bl_ready[%0d] got=%b exp=0010", b, bus.req_ready); end
      checks++; if (busy !== (b != 0)) begin failures++; $display("FAIL bl_busy[%0d] got=%b exp=%b", b, busy, (b != 0)); end
      checks++; if (mem_wdata !== exp_d || mem_addr !== AW'(16'h0020 + b)) begin failures++; $display("FAIL bl_bus[%0d] got addr=%h wdata=%h exp addr=%h wdata=%h", b, mem_addr, mem_wdata, AW'(16'h0020 + b), exp_d); end
      checks++; if (bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL bl_no_rsp[%0d] got=%b exp=0000", b, bus.rsp_valid); end
      step();
    end
    bus.req_valid[1] = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL bl_req2_ready got=%b exp=0100", bus.req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bl_busy_end got=%b exp=0", busy); end
    step();
    clr_all();
    #1;
    checks++; if (bus.rsp_valid !== 4'b0100) begin failures++; $display("FAIL bl_req2_rsp got=%b exp=0100", bus.rsp_valid); end
  endtask

  task automatic test_max_burst();
    apply_reset();
    set_req(0, 1'b1, 1'b1, 1'b0, 16'h0050, 32'h5555_0000);
    set_req(3, 1'b1, 1'b0, 1'b1, 16'h0030, '0);
    #1;
    checks++; if (bus.req_ready !== 4'b0001 || busy !== 1'b0) begin failures++; $display("FAIL mb_beat1 got ready=%b busy=%b exp ready=0001 busy=0", bus.req_ready, busy); end
    step(); #1;
    checks++; if (bus.req_ready !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL mb_beat2 got ready=%b busy=%b exp ready=0001 busy=1", bus.req_ready, busy); end
    step();
    bus.req_valid[0] = 1'b0;
    #1;
    checks++; if ((bus.req_ready & 4'b1110) !== 4'b0000 || mem_ce !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL mb_idle got ready=%b ce=%b busy=%b exp ready[3:1]=000 ce=0 busy=1", bus.req_ready, mem_ce, busy); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL mb_idle_gid got=%0d exp=0", grant_id); end
    step();
    bus.req_valid[0] = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL mb_beat3 got=%b exp=0001", bus.req_ready); end
    step(); #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL mb_beat4 got=%b exp=0001", bus.req_ready); end
    step(); #1;
    checks++; if (bus.req_ready !== 4'b1000 || busy !== 1'b0) begin failures++; $display("FAIL mb_release got ready=%b busy=%b exp ready=1000 busy=0", bus.req_ready, busy); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 16'h0030) begin failures++; $display("FAIL mb_req3_bus got we=%b addr=%h exp we=0 addr=0030", mem_we, mem_addr); end
    step();
    bus.req_valid[3] = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0001 || busy !== 1'b0) begin failures++; $display("FAIL mb_resume got ready=%b busy=%b exp ready=0001 busy=0", bus.req_ready, busy); end
    checks++; if (bus.rsp_valid !== 4'b1000 || grant_id !== 2'd3) begin failures++; $display("FAIL mb_req3_rsp got rsp=%b gid=%0d exp rsp=1000 gid=3", bus.rsp_valid, grant_id); end
    step(); #1;
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin failures++; $display("FAIL mb_relock got busy=%b gid=%0d exp busy=1 gid=0", busy, grant_id); end
    step();
    clr_all();
  endtask

  task automatic test_write_read();
    apply_reset();
    set_req(2, 1'b1, 1'b1, 1'b1, 16'h0100, 32'h0000_1234);
    #1;
    checks++; if (bus.req_ready !== 4'b0100 || mem_we !== 1'b1) begin failures++; $display("FAIL wr_write got ready=%b we=%b exp ready=0100 we=1", bus.req_ready, mem_we); end
    step();
    bus.req_we[2] = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0100 || mem_we !== 1'b0 || mem_addr !== 16'h0100) begin failures++; $display("FAIL wr_read got ready=%b we=%b addr=%h exp ready=0100 we=0 addr=0100", bus.req_ready, mem_we, mem_addr); end
    step();
    clr_all();
    #1;
    checks++; if (bus.rsp_valid !== 4'b0100) begin failures++; $display("FAIL wr_rsp_valid got=%b exp=0100", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0000_1234) begin failures++; $display("FAIL wr_rsp_rdata got=%h exp=00001234", bus.rsp_rdata); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    set_req(1, 1'b1, 1'b0, 1'b0, 16'h0060, '0);
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL rm_beat1 got=%b exp=0010", bus.req_ready); end
    step(); #1;
    checks++; if (busy !== 1'b1 || bus.rsp_valid !== 4'b0010) begin failures++; $display("FAIL rm_beat2 got busy=%b rsp=%b exp busy=1 rsp=0010", busy, bus.rsp_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0000 || mem_ce !== 1'b0) begin failures++; $display("FAIL rm_gate got ready=%b ce=%b exp ready=0000 ce=0", bus.req_ready, mem_ce); end
    checks++; if (bus.rsp_valid !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL rm_clear got rsp=%b busy=%b exp rsp=0000 busy=0", bus.rsp_valid, busy); end
    step();
    step();
    rst_n = 1'b1;
    clr_all();
    set_req(0, 1'b1, 1'b0, 1'b1, 16'h0070, '0);
    set_req(3, 1'b1, 1'b0, 1'b1, 16'h0071, '0);
    #1;
    checks++; if (bus.req_ready !== 4'b0001 || busy !== 1'b0) begin failures++; $display("FAIL rm_restart got ready=%b busy=%b exp ready=0001 busy=0", bus.req_ready, busy); end
    step();
    clr_all();
    #1;
    checks++; if (bus.rsp_valid !== 4'b0001 || grant_id !== 2'd0) begin failures++; $display("FAIL rm_restart_rsp got rsp=%b gid=%0d exp rsp=0001 gid=0", bus.rsp_valid, grant_id); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clr_all();
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_lock();
    test_max_burst();
    test_write_read();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
